// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ceiling log2 of v (number of bits needed to index v distinct values).
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

   // Bit-step counter width for a given operand width.
   function automatic int unsigned cnt_width(input int unsigned w);
      return clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_sub_fsub_cell.sv
// One-bit combinational full subtractor: d = x - y - bi, bo = borrow out.
module fsub_cell (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional two's-complement overflow output enabled by macro SERIAL_SUB_OVF_EN.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           r_state;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-2:0] r_res;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
`ifdef SERIAL_SUB_OVF_EN
   logic             r_amsb;
   logic             r_bmsb;
`endif

   logic             w_d;
   logic             w_bo;
   logic             w_last;
   logic [WIDTH-1:0] w_cat;

   // Single shared subtractor cell working on the current LSBs.
   fsub_cell u_cell (
      .x  (r_sa[0]),
      .y  (r_sb[0]),
      .bi (r_borrow),
      .d  (w_d),
      .bo (w_bo)
   );

   // New difference bit joins the partial result on the MSB side.
   assign w_cat  = {w_d, r_res};
   assign w_last = (r_cnt == CW'(WIDTH - 1));

   // Control FSM, operand shifters and registered result/handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_sa     <= '0;
         r_sb     <= '0;
         r_res    <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         ready    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         diff     <= '0;
         bout     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_amsb   <= 1'b0;
         r_bmsb   <= 1'b0;
         ovf      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_sa     <= a;
                  r_sb     <= b;
                  r_borrow <= bin;
                  r_res    <= '0;
                  r_cnt    <= '0;
                  r_state  <= RUN;
                  ready    <= 1'b0;
                  busy     <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                  r_amsb   <= a[WIDTH-1];
                  r_bmsb   <= b[WIDTH-1];
`endif
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
               r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
               r_res    <= w_cat[WIDTH-1:1];
               r_borrow <= w_bo;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  diff    <= w_cat;
                  bout    <= w_bo;
                  done    <= 1'b1;
                  ready   <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                  ovf     <= (r_amsb != r_bmsb) && (w_d != r_amsb);
`endif
               end
            end
            default: begin
               r_state <= IDLE;
               ready   <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=4 directed, WIDTH=8 random).
module tb_serial_sub;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic       s4, bin4, rdy4, busy4, done4, bout4;
   logic [3:0] a4, b4, diff4;
   logic       s8, bin8, rdy8, busy8, done8, bout8;
   logic [7:0] a8, b8, diff8;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf4, ovf8;
`endif

   serial_sub #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .bin(bin4),
      .ready(rdy4), .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(ovf4)
`endif
   );

   serial_sub #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bin8),
      .ready(rdy8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
      , .ovf(ovf8)
`endif
   );

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       bin;
      logic [3:0] diff;
      logic       bout;
      logic       ovf;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed range test for overflow.
   function automatic void ref_sub(input int w, input int ia, input int ib, input int ibin,
                                   output int d, output bit bo, output bit ov);
      int full, sa, sb, sr;
      full = ia - ib - ibin;
      d    = full & ((1 << w) - 1);
      bo   = (ia < ib + ibin);
      sa   = (ia >= (1 << (w - 1))) ? ia - (1 << w) : ia;
      sb   = (ib >= (1 << (w - 1))) ? ib - (1 << w) : ib;
      sr   = sa - sb - ibin;
      ov   = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
   endfunction

   // One WIDTH=4 operation; returns edges from accept to done and a handshake-error flag.
   task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                      output int lat, output logic hs_bad);
      @(negedge clk);
      s4 = 1'b1; a4 = ia; b4 = ib; bin4 = ibin;
      @(posedge clk); #1;
      s4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      lat = 0; hs_bad = 1'b0;
      while (!done4 && lat < 20) begin
         if (rdy4 || !busy4) hs_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                      output int lat);
      @(negedge clk);
      s8 = 1'b1; a8 = ia; b8 = ib; bin8 = ibin;
      @(posedge clk); #1;
      s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      lat = 0;
      while (!done8 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int   lat, ed;
      bit   ebo, eov;
      logic hs_bad, seen;
      logic [3:0] va[12], vb[12];
      logic       vbin[12];

      s4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
      s8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;

      tbl[0] = '{4'd9,  4'd5,  1'b0, 4'd4,  1'b0, 1'b1};
      tbl[1] = '{4'd3,  4'd5,  1'b0, 4'd14, 1'b1, 1'b0};
      tbl[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0};
      tbl[3] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
      tbl[4] = '{4'd7,  4'd15, 1'b0, 4'd8,  1'b1, 1'b1};
      tbl[5] = '{4'd5,  4'd2,  1'b0, 4'd3,  1'b0, 1'b0};
      tbl[6] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
      tbl[7] = '{4'd6,  4'd9,  1'b1, 4'd12, 1'b1, 1'b1};

      // Reset state
      #12;
      check("rst_ready", 32'(rdy4), 32'd1);
      check("rst_busy",  32'(busy4), 32'd0);
      check("rst_done",  32'(done4), 32'd0);
      check("rst_diff",  32'(diff4), 32'd0);
      check("rst_bout",  32'(bout4), 32'd0);
      check("rst_ready8", 32'(rdy8), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", 32'(ovf4), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 8; i++) begin
         op4(tbl[i].a, tbl[i].b, tbl[i].bin, lat, hs_bad);
         check($sformatf("tbl%0d_lat", i),  32'(lat), 32'd4);
         check($sformatf("tbl%0d_diff", i), 32'(diff4), 32'(tbl[i].diff));
         check($sformatf("tbl%0d_bout", i), 32'(bout4), 32'(tbl[i].bout));
         check($sformatf("tbl%0d_hs", i),   32'(hs_bad), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
         check($sformatf("tbl%0d_ovf", i),  32'(ovf4), 32'(tbl[i].ovf));
`endif
      end
      @(posedge clk); #1;
      check("hold_done", 32'(done4), 32'd0);
      check("hold_diff", 32'(diff4), 32'(tbl[7].diff));
      check("hold_ready", 32'(rdy4), 32'd1);

      // Start held high through RUN: accepts at edge 0 (IDLE) and edge 5 (DONE)
      for (int c = 0; c < 12; c++) begin
         va[c] = 4'($urandom); vb[c] = 4'($urandom); vbin[c] = 1'($urandom);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         s4 = (c <= 5); a4 = va[c]; b4 = vb[c]; bin4 = vbin[c];
         @(posedge clk); #1;
         if (c == 4 || c == 9) begin
            int k;
            k = (c == 4) ? 0 : 5;
            ref_sub(4, int'(va[k]), int'(vb[k]), int'(vbin[k]), ed, ebo, eov);
            check($sformatf("b2b_done_e%0d", c), 32'(done4), 32'd1);
            check($sformatf("b2b_diff_e%0d", c), 32'(diff4), 32'(ed));
            check($sformatf("b2b_bout_e%0d", c), 32'(bout4), 32'(ebo));
         end else begin
            check($sformatf("b2b_nodone_e%0d", c), 32'(done4), 32'd0);
         end
      end
      s4 = 1'b0;

      // Asynchronous reset at RUN step 2
      op4(4'd5, 4'd2, 1'b0, lat, hs_bad);
      check("prerst_diff", 32'(diff4), 32'd3);
      @(negedge clk);
      s4 = 1'b1; a4 = 4'd12; b4 = 4'd3; bin4 = 1'b0;
      @(posedge clk); #1;
      s4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #1 rst_n = 1'b0;
      #1;
      check("arst_ready", 32'(rdy4), 32'd1);
      check("arst_busy",  32'(busy4), 32'd0);
      check("arst_done",  32'(done4), 32'd0);
      check("arst_diff",  32'(diff4), 32'd0);
      check("arst_bout",  32'(bout4), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (done4 || busy4) seen = 1'b1;
      end
      check("arst_no_done", 32'(seen), 32'd0);
      op4(4'd12, 4'd3, 1'b0, lat, hs_bad);
      check("post_rst_lat",  32'(lat), 32'd4);
      check("post_rst_diff", 32'(diff4), 32'd9);
      check("post_rst_bout", 32'(bout4), 32'd0);

      // WIDTH=8 random regression against the reference model
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ra, rb;
         logic       rbin;
         ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         op8(ra, rb, rbin, lat);
         ref_sub(8, int'(ra), int'(rb), int'(rbin), ed, ebo, eov);
         check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd8);
         check($sformatf("rnd%0d_res a=%0h b=%0h bin=%0b", i, ra, rb, rbin),
               {23'd0, bout8, diff8}, {23'd0, 1'(ebo), 8'(ed)});
`ifdef SERIAL_SUB_OVF_EN
         check($sformatf("rnd%0d_ovf", i), 32'(ovf8), 32'(eov));
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial subtractor: computes diff = a - b - bin over WIDTH clock cycles, one bit per cycle, LSB first.
- Complements the team's combinational ripple-carry adder: subtraction direction, traded for area.
- Sits in datapaths where one full-subtractor cell plus shift registers replaces a WIDTH-bit ripple-borrow chain.
- Start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while ready=1
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- ready  output  1  high in IDLE and DONE; start is accepted
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  result, held until the next completion
- bout  output  1  borrow-out (1 when a < b + bin, unsigned)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0. Internal shift registers, borrow flop and counter are 0.
- States:
  - IDLE -> RUN on start.
  - RUN -> DONE after WIDTH bit steps.
  - DONE -> IDLE, or DONE -> RUN on start.
- Accept edge k (start=1, ready=1):
  - Latch a and b into shift registers.
  - Borrow flop = bin, count = 0, state = RUN.
- RUN edge (bit step):
  - Full-subtractor on (sa[0], sb[0], borrow) gives d = sa[0]^sb[0]^borrow and bnext = (~sa[0]&sb[0]) | (~sa[0]&borrow) | (sb[0]&borrow).
  - d shifts into the result register MSB side; sa and sb shift right; borrow <= bnext; count++.
- Completion:
  - At edge k+WIDTH, the last step loads diff with the full result and bout with the final borrow.
  - state = DONE, done = 1.
  - Latency from accept edge to done high: exactly WIDTH cycles.
- DONE lasts one cycle; done deasserts at the next edge.
- Back-to-back: start in DONE is accepted at that edge. The next operation begins with no idle bubble and done pulses separately.
- start while busy: ignored; operands are not re-captured and there is no error flag.
- Operand inputs are don't-care except at the accept edge.
- diff and bout change only at completion edges; partial results are never visible.
- Asynchronous reset mid-RUN: immediate return to the reset values; the in-flight operation is discarded and no done is produced.
- Arithmetic is modulo 2^WIDTH. Example: a=0, b=0, bin=1 gives diff = all ones, bout = 1.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- When defined, add output ovf (1 bit, reset 0), loaded at the completion edge together with diff.
- ovf is two's-complement overflow of a - b - bin: ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- Implementation: capture the a and b MSBs at the accept edge.
- When undefined: no ovf port and no associated flops.

Decomposition:
- Package serial_sub_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits.
  - Counter-width function clog2(WIDTH+1).
- Sub-module fsub_cell: combinational 1-bit full subtractor (x, y, bi -> d, bo), instantiated once.

Test Plan:
- WIDTH=4, a=9, b=5, bin=0: done exactly 4 cycles after the accept edge, diff=4, bout=0, ready low during RUN.
- a=3, b=5, bin=0 -> diff=14, bout=1. Then a=0, b=0, bin=1 -> diff=15, bout=1.
- start held high through RUN with changing a/b: a second start is accepted only in DONE, results match the operands at each accept edge, and done pulses twice with no bubble.
- rst_n low for 1 cycle at RUN step 2 of a=12, b=3: outputs are at reset values immediately, no done follows, and the next op a=12, b=3 gives diff=9.
- With SERIAL_SUB_OVF_EN:
  - a=8, b=1 -> diff=7, ovf=1.
  - a=7, b=15 -> diff=8, ovf=1, bout=1.
  - a=5, b=2 -> ovf=0.
- WIDTH=8 random regression, 1000 ops versus the reference model (a-b-bin) mod 256 with bout = (a < b+bin): zero mismatches.
